// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 5x4 matrix keypad scanner with frame-based debouncing. Drives one
//            active-low row at a time, samples the synchronised active-low
//            columns, reduces each 5-row frame to (hit, lowest code) and
//            debounces that result into a stable keycode / ready level.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [4:0] row,
    output logic [4:0] keycode,
    output logic       ready,
    output logic       pressed
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_ROW   = 3'd4;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    // Column synchroniser
    logic [3:0]       col_meta;
    logic [3:0]       col_sync;

    // Scan timing
    logic [DIV_W-1:0] dwell;
    logic [2:0]       row_idx;
    logic             sample_now;

    // Per-sample decode of the current row
    logic             col_hit;
    logic [1:0]       col_sel;
    logic [4:0]       row_code;

    // Frame accumulation and the registered per-frame result
    logic             acc_hit;
    logic [4:0]       acc_code;
    logic             frame_valid;
    logic             frame_hit;
    logic [4:0]       frame_code;

    // Debounce state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       cand;
    logic             key_match;

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    assign sample_now = (dwell == DIV_LAST);

    // Dwell counter and row rotation; the row moves on the cycle after its sample
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell   <= '0;
            row_idx <= 3'd0;
            row     <= 5'b11110;
        end else if (sample_now) begin
            dwell <= '0;
            row   <= {row[3:0], row[4]};
            if (row_idx == LAST_ROW) begin
                row_idx <= 3'd0;
            end else begin
                row_idx <= row_idx + 3'd1;
            end
        end else begin
            dwell <= dwell + DIV_W'(1);
        end
    end

    // Lowest active column of the current row, combined with the row index
    always_comb begin
        col_hit = ~(&col_sync);
        col_sel = 2'd0;
        if (!col_sync[0]) begin
            col_sel = 2'd0;
        end else if (!col_sync[1]) begin
            col_sel = 2'd1;
        end else if (!col_sync[2]) begin
            col_sel = 2'd2;
        end else if (!col_sync[3]) begin
            col_sel = 2'd3;
        end
    end

    // row_index*4 + col_index is simply the concatenation of the two indices
    assign row_code = {row_idx, col_sel};

    // Frame accumulator: rows are scanned in ascending order, so the first hit
    // of a frame is automatically the lowest code in it
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hit     <= 1'b0;
            acc_code    <= 5'd0;
            frame_valid <= 1'b0;
            frame_hit   <= 1'b0;
            frame_code  <= 5'd0;
        end else begin
            frame_valid <= 1'b0;
            if (sample_now) begin
                if (row_idx == LAST_ROW) begin
                    frame_valid <= 1'b1;
                    frame_hit   <= acc_hit | col_hit;
                    frame_code  <= acc_hit ? acc_code : row_code;
                    acc_hit     <= 1'b0;
                    acc_code    <= 5'd0;
                end else if (!acc_hit && col_hit) begin
                    acc_hit  <= 1'b1;
                    acc_code <= row_code;
                end
            end
        end
    end

    assign cnt_inc   = cnt + CNT_ONE;
    assign key_match = frame_hit && (frame_code == keycode);

    // Debounce FSM, advanced once per completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cand    <= 5'd0;
            keycode <= 5'd0;
            ready   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            pressed <= 1'b0;
            if (frame_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (frame_hit) begin
                            if (DEBOUNCE == 1) begin
                                keycode <= frame_code;
                                ready   <= 1'b1;
                                pressed <= 1'b1;
                                state   <= ST_HELD;
                            end else begin
                                cand  <= frame_code;
                                cnt   <= CNT_ONE;
                                state <= ST_PRESS_CHK;
                            end
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (frame_hit && (frame_code == cand)) begin
                            if (cnt_inc == DEB_TARGET) begin
                                keycode <= cand;
                                ready   <= 1'b1;
                                pressed <= 1'b1;
                                state   <= ST_HELD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else if (frame_hit) begin
                            cand <= frame_code;
                            cnt  <= CNT_ONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        // A different key while held is treated as a release
                        if (!key_match) begin
                            if (DEBOUNCE == 1) begin
                                ready <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                cnt   <= CNT_ONE;
                                state <= ST_RELEASE_CHK;
                            end
                        end
                    end
                    ST_RELEASE_CHK: begin
                        if (key_match) begin
                            state <= ST_HELD;
                        end else if (cnt_inc == DEB_TARGET) begin
                            ready <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3).
//            A key-set model drives the columns from the row outputs; a
//            frame-history reference model predicts ready/keycode/pressed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int D  = 3;
    localparam int FR = 5 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic [4:0] row;
    logic [4:0] keycode;
    logic       ready;
    logic       pressed;

    logic [19:0] keys = 20'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of frame codes (-1 = no key)
    int          hist[$];
    int          epoch;
    bit          m_ready;
    logic [4:0]  m_keycode;
    bit          m_press;
    int          prev_code;
    bit          prev_valid;
    int          obs_press;
    int          exp_press;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .col     (col),
        .row     (row),
        .keycode (keycode),
        .ready   (ready),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its column low while its row is driven
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4 + c]) col[c] = 1'b0;
                end
            end
        end
    end

    function automatic int lowest(input logic [19:0] k);
        for (int i = 0; i < 20; i++) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    // A press is accepted once the last D frames since the previous decision
    // all show the same key; a release once the last D frames all lack the key.
    task automatic model_eval(input int code);
        int n;
        bit all_ok;
        hist.push_back(code);
        m_press = 1'b0;
        n = hist.size();
        if (n - epoch >= D) begin
            all_ok = 1'b1;
            for (int j = n - D; j < n; j++) begin
                if (!m_ready) begin
                    if (hist[j] != code || code < 0) all_ok = 1'b0;
                end else begin
                    if (hist[j] == int'(m_keycode)) all_ok = 1'b0;
                end
            end
            if (all_ok) begin
                if (!m_ready) begin
                    m_ready   = 1'b1;
                    m_keycode = code[4:0];
                    m_press   = 1'b1;
                end else begin
                    m_ready = 1'b0;
                end
                epoch = n;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        epoch      = 0;
        m_ready    = 1'b0;
        m_keycode  = 5'd0;
        m_press    = 1'b0;
        prev_valid = 1'b0;
    endtask

    // One-cycle reset pulse, aligned so a fresh frame starts right after it
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Hold key set k for n cycles starting at a frame boundary; the previous
    // frame is evaluated on the first edge of this one
    task automatic run_frame(input logic [19:0] k, input int n);
        keys      = k;
        obs_press = 0;
        exp_press = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0 && prev_valid) begin
                model_eval(prev_code);
                exp_press = int'(m_press);
            end
            if (pressed) obs_press++;
        end
        prev_code  = lowest(k);
        prev_valid = (n == FR);
    endtask

    task automatic test_reset();
        logic [4:0] exp_row;
        keys = 20'd0;
        do_reset();
        n_cmp++; if (row !== 5'b11110) begin n_bad++; $display("FAIL reset_row got %b want 11110", row); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (pressed !== 1'b0) begin n_bad++; $display("FAIL reset_pressed got %b want 0", pressed); end
        n_cmp++; if (keycode !== 5'd0) begin n_bad++; $display("FAIL reset_keycode got %0d want 0", keycode); end
        for (int i = 0; i < 3 * FR; i++) begin
            @(posedge clk);
            #1;
            exp_row = 5'b00001 << (((i + 1) / SD) % 5);
            exp_row = ~exp_row;
            n_cmp++; if (row !== exp_row) begin n_bad++; $display("FAIL idle_row cycle %0d got %b want %b", i, row, exp_row); end
            n_cmp++; if (ready !== 1'b0 || pressed !== 1'b0) begin n_bad++; $display("FAIL idle_outputs cycle %0d got ready=%b pressed=%b want 0/0", i, ready, pressed); end
        end
    endtask

    task automatic test_single_press();
        int total;
        total = 0;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            run_frame(20'd1 << 4, FR);
            total += obs_press;
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL single_ready frame %0d got %b want %b", f, ready, m_ready); end
            n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL single_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
            n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL single_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
        end
        n_cmp++; if (ready !== 1'b1 || keycode !== 5'd4) begin n_bad++; $display("FAIL single_final got ready=%b code=%0d want 1/4", ready, keycode); end
        n_cmp++; if (total != 1) begin n_bad++; $display("FAIL single_pulse_count got %0d want 1", total); end
    endtask

    task automatic test_bounce();
        int seq[9] = '{13, 13, -1, 13, 13, 13, 13, 13, 13};
        logic [19:0] k;
        do_reset();
        for (int f = 0; f < 9; f++) begin
            k = (seq[f] < 0) ? 20'd0 : (20'd1 << seq[f]);
            run_frame(k, FR);
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL bounce_ready frame %0d got %b want %b", f, ready, m_ready); end
            n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL bounce_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
            n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL bounce_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
            // Frame 5 completes the third consecutive frame; it is evaluated in frame 6
            if (f == 5) begin
                n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bounce_early got %b want 0", ready); end
            end
        end
        n_cmp++; if (ready !== 1'b1 || keycode !== 5'd13) begin n_bad++; $display("FAIL bounce_final got ready=%b code=%0d want 1/13", ready, keycode); end
    endtask

    task automatic test_multi_key();
        logic [19:0] k;
        bit saw_drop;
        saw_drop = 1'b0;
        do_reset();
        for (int f = 0; f < 18; f++) begin
            k = (f < 5) ? ((20'd1 << 4) | (20'd1 << 13)) : (20'd1 << 13);
            run_frame(k, FR);
            if (f >= 5 && ready === 1'b0) saw_drop = 1'b1;
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL multi_ready frame %0d got %b want %b", f, ready, m_ready); end
            n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL multi_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
            n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL multi_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
            if (f == 4) begin
                n_cmp++; if (ready !== 1'b1 || keycode !== 5'd4) begin n_bad++; $display("FAIL multi_lowest got ready=%b code=%0d want 1/4", ready, keycode); end
            end
        end
        n_cmp++; if (!saw_drop) begin n_bad++; $display("FAIL multi_release got no drop want drop"); end
        n_cmp++; if (ready !== 1'b1 || keycode !== 5'd13) begin n_bad++; $display("FAIL multi_final got ready=%b code=%0d want 1/13", ready, keycode); end
    endtask

    task automatic test_dropout();
        int seq[14] = '{19, 19, 19, 19, 19, -1, 19, 19, 19, -1, -1, -1, -1, -1};
        logic [19:0] k;
        int total;
        total = 0;
        do_reset();
        for (int f = 0; f < 14; f++) begin
            k = (seq[f] < 0) ? 20'd0 : (20'd1 << seq[f]);
            run_frame(k, FR);
            total += obs_press;
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL dropout_ready frame %0d got %b want %b", f, ready, m_ready); end
            n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL dropout_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
            n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL dropout_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
            // Empty frames 9,10,11: ready still high until frame 11 is evaluated
            if (f == 11) begin
                n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL dropout_hold got %b want 1", ready); end
            end
            if (f == 12) begin
                n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL dropout_release got %b want 0", ready); end
            end
        end
        n_cmp++; if (total != 1) begin n_bad++; $display("FAIL dropout_pulse_count got %0d want 1", total); end
        n_cmp++; if (keycode !== 5'd19) begin n_bad++; $display("FAIL dropout_keep_code got %0d want 19", keycode); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int f = 0; f < 5; f++) run_frame(20'd1 << 7, FR);
        n_cmp++; if (ready !== 1'b1 || keycode !== 5'd7) begin n_bad++; $display("FAIL midrst_pre got ready=%b code=%0d want 1/7", ready, keycode); end
        run_frame(20'd1 << 7, $urandom_range(1, FR - 1));
        do_reset();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b want 0", ready); end
        n_cmp++; if (keycode !== 5'd0) begin n_bad++; $display("FAIL midrst_keycode got %0d want 0", keycode); end
        n_cmp++; if (row !== 5'b11110) begin n_bad++; $display("FAIL midrst_row got %b want 11110", row); end
        for (int f = 0; f < 5; f++) begin
            run_frame(20'd1 << 7, FR);
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL midrst_ready frame %0d got %b want %b", f, ready, m_ready); end
            n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL midrst_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
            n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL midrst_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
        end
        n_cmp++; if (ready !== 1'b1 || keycode !== 5'd7) begin n_bad++; $display("FAIL midrst_final got ready=%b code=%0d want 1/7", ready, keycode); end
    endtask

    task automatic test_random();
        logic [19:0] k;
        int hold;
        int kind;
        int f;
        f = 0;
        do_reset();
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       k = 20'd0;
                3:       k = (20'd1 << $urandom_range(0, 19)) | (20'd1 << $urandom_range(0, 19));
                default: k = 20'd1 << $urandom_range(0, 19);
            endcase
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                run_frame(k, FR);
                f++;
                n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL random_ready frame %0d got %b want %b", f, ready, m_ready); end
                n_cmp++; if (keycode !== m_keycode) begin n_bad++; $display("FAIL random_keycode frame %0d got %0d want %0d", f, keycode, m_keycode); end
                n_cmp++; if (obs_press != exp_press) begin n_bad++; $display("FAIL random_pressed frame %0d got %0d want %0d", f, obs_press, exp_press); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_dropout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner and debouncer feeding the piano keypad decoder. Drives a 5-row by 4-column switch matrix one row at a time and samples the columns. It debounces the result over whole scan frames and presents a stable 5-bit keycode with a level `ready` that stays high while exactly one debounced key is held. Downstream logic uses `ready` as a level and detects edges itself; `pressed` is provided as a convenience strobe.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row is driven (dwell); legal range ≥ 4.
- `DEBOUNCE`, 4: consecutive agreeing frames required to accept a press or a release; legal range ≥ 1.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `col`  in  4  column inputs, active-low, externally pulled up, asynchronous to `clk`.
- `row`  out  5  row drives, active-low one-hot, registered.
- `keycode`  out  5  debounced key, `row_index*4 + col_index`, range 0..19.
- `ready`  out  1  high while a debounced key is held; `keycode` is stable whenever `ready`=1.
- `pressed`  out  1  one-cycle strobe on the cycle `ready` rises.

## Operation
- **Synchroniser:** `col` passes through a 2-flop synchroniser, reset value 4'b1111.
- **Scan:**
  - Dwell counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronised columns are sampled for the current row, then `row` rotates to the next row: 0→1→2→3→4→0.
  - A frame is the 5 row dwells, 5*SCAN_DIV cycles.
- **Frame evaluation:**
  - `hit`=1 if any column is low in any row during the frame.
  - `code` is the lowest keycode seen: lowest row first, then lowest column.
  - Multiple simultaneous keys therefore resolve to the lowest code; they are not rejected.
- **Debounce FSM:** evaluated once per frame, on the cycle after the row-4 sample. `cnt` is a frame counter and `cand` a candidate register, each wide enough for its range.
  - **IDLE** (`ready`=0):
    - `hit` → `cand`=`code`, `cnt`=1, go to PRESS_CHK.
    - If DEBOUNCE=1, go directly to HELD instead.
  - **PRESS_CHK:**
    - `hit` and `code`=`cand` → `cnt`+1. On reaching DEBOUNCE: `keycode`=`cand`, `ready`=1, `pressed`=1, go to HELD.
    - `hit` with a different code → `cand`=`code`, `cnt`=1.
    - No `hit` → IDLE.
  - **HELD:**
    - `hit` and `code`=`keycode` → stay.
    - Otherwise → `cnt`=1, go to RELEASE_CHK; `ready` stays 1.
  - **RELEASE_CHK:**
    - `hit` and `code`=`keycode` → back to HELD.
    - Otherwise `cnt`+1. On reaching DEBOUNCE: `ready`=0, go to IDLE.
    - If DEBOUNCE=1, HELD goes directly to IDLE.
- **Key change while held:** a different key while held counts as a release. The new key is then debounced from IDLE. `keycode` never changes while `ready`=1.
- **After release:** `keycode` keeps its last value when `ready` falls.

## Timing
- **Reset values:**
  - `row`=5'b11110, dwell counter 0, row index 0.
  - `ready`=0, `pressed`=0, `keycode`=0, state IDLE, `cnt`=0, `cand`=0, frame accumulators cleared.
- **Reset mid-operation:** takes effect on the next `clk` edge from any state. The scan restarts at row 0 and any partial frame is discarded.
- **Row timing:** `row` changes on the cycle after the count SCAN_DIV-1 sample. The columns therefore settle for SCAN_DIV-1 cycles, minus 2 synchroniser cycles, before the next sample.
- **Press latency:** for a key stable from the start of frame k, `ready` and `pressed` rise on the evaluation cycle following frame k+DEBOUNCE-1.
- **Release latency:** `ready` falls DEBOUNCE frames after the first frame without that key.
- **`pressed`:** high for exactly one cycle per accepted press.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, so a frame is 20 cycles.

1. Reset, no keys → `row` cycles 11110, 11101, 11011, 10111, 01111, each for 4 cycles. `ready`=0, `pressed`=0 indefinitely.
2. Hold key at row 1, col 0 (`col[0]`=0 whenever `row[1]`=0) from reset → after 3 full frames: `ready`=1, `keycode`=4, a single `pressed` pulse. `ready` stays 1 while the key is held.
3. Bounce: key code 13 (row 3, col 1) present 2 frames, absent 1, present 3 → `ready` rises only after the final 3 consecutive frames, with `keycode`=13.
4. Keys 4 and 13 held together → `keycode`=4, `ready`=1. Releasing key 4 while 13 stays held → `ready` falls after 3 frames, then rises again after 3 more with `keycode`=13.
5. Held key 19 → a 1-frame dropout keeps `ready`=1 with no `pressed` pulse. A full release drops `ready` after exactly 3 empty frames, and `keycode` stays 19.
6. `rst` pulsed for 1 cycle while `ready`=1 → next cycle `ready`=0, `keycode`=0, `row`=11110. With the key still held, `ready` returns 3 frames later.
